pipeline_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage MIPS pipeline; directly consumes the ID-stage operand proxy's load_related_1/load_related_2 outputs.
- Merges per-stage stall requests into a per-stage stall vector.
- Sequences exception/ERET flushes and the PC redirect, holding a pending redirect target while an instruction fetch is still outstanding.

---
 rtl/pipeline_ctrl_if.sv | 33 +++
 rtl/pipeline_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// Pipeline-side signal bundle for pipeline_ctrl: stall requests and flush/redirect results.
// The pipeline stages drive through master; the controller attaches through slave.
interface pipeline_ctrl_if;
    logic        request_from_if;
    logic        load_related_1;
    logic        load_related_2;
    logic        request_from_ex;
    logic        request_from_mem;
    logic        exception_flag;
    logic        eret_flag;
    logic [31:0] epc;
    logic [5:0]  stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_timeout;
    logic [31:0] load_stall_cnt;
    logic [31:0] total_stall_cnt;

    modport master (
        output request_from_if, load_related_1, load_related_2, request_from_ex,
               request_from_mem, exception_flag, eret_flag, epc,
        input  stall, flush, redirect_valid, redirect_pc, fetch_timeout,
               load_stall_cnt, total_stall_cnt
    );

    modport slave (
        input  request_from_if, load_related_1, load_related_2, request_from_ex,
               request_from_mem, exception_flag, eret_flag, epc,
        output stall, flush, redirect_valid, redirect_pc, fetch_timeout,
               load_stall_cnt, total_stall_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage pipeline, with redirects held while a fetch is pending.
// Optional performance counters are enabled with `define PIPELINE_PERF_CNT_EN.
module pipeline_ctrl #(
    parameter logic [31:0] EXC_VECTOR    = 32'hBFC00380,
    parameter int unsigned FETCH_TIMEOUT = 64,
    parameter int unsigned CNT_W         = 8
) (
    input logic           clk,
    input logic           rst,
    pipeline_ctrl_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StWaitFetch} state_e;

    state_e             state_q, state_d;
    logic [31:0]        pending_q, pending_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_q, timeout_d;

    logic               load_related;
    logic               redirect_req;
    logic [31:0]        target;
    logic [5:0]         stall_vec;

    logic [5:0]         stall;
    logic               flush;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;

    assign load_related = bus.load_related_1 | bus.load_related_2;
    // A MEM stall defers the redirect; the MEM stage keeps its flag asserted meanwhile.
    assign redirect_req = (bus.exception_flag | bus.eret_flag) & ~bus.request_from_mem;
    assign target       = bus.exception_flag ? EXC_VECTOR : bus.epc;

    always_comb begin
        if (bus.request_from_mem) begin
            stall_vec = 6'b011111;
        end else if (bus.request_from_ex) begin
            stall_vec = 6'b001111;
        end else if (load_related) begin
            stall_vec = 6'b000111;
        end else if (bus.request_from_if) begin
            stall_vec = 6'b000011;
        end else begin
            stall_vec = 6'b000000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            pending_q <= 32'h0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        unique case (state_q)
            StIdle: begin
                if (redirect_req && bus.request_from_if) begin
                    state_d   = StWaitFetch;
                    pending_d = target;
                    cnt_d     = '0;
                end
            end
            StWaitFetch: begin
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (cnt_d >= CNT_W'(FETCH_TIMEOUT)) begin
                    timeout_d = 1'b1;
                end
                if (redirect_req) begin
                    pending_d = target;
                end
                if (!bus.request_from_if) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        stall          = 6'b000000;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if (!rst) begin
            unique case (state_q)
                StIdle: begin
                    if (redirect_req) begin
                        flush       = 1'b1;
                        redirect_pc = target;
                        if (bus.request_from_if) begin
                            stall = 6'b000011;
                        end else begin
                            redirect_valid = 1'b1;
                        end
                    end else begin
                        stall = stall_vec;
                    end
                end
                StWaitFetch: begin
                    stall       = 6'b000011;
                    flush       = redirect_req;
                    redirect_pc = pending_q;
                    if (!bus.request_from_if) begin
                        redirect_valid = 1'b1;
                        if (redirect_req) begin
                            redirect_pc = target;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.stall          = stall;
    assign bus.flush          = flush;
    assign bus.redirect_valid = redirect_valid;
    assign bus.redirect_pc    = redirect_pc;
    assign bus.fetch_timeout  = timeout_q;

`ifdef PIPELINE_PERF_CNT_EN
    logic [31:0] load_cnt_q;
    logic [31:0] total_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt_q  <= 32'h0;
            total_cnt_q <= 32'h0;
        end else begin
            if (load_related && stall[2] && (load_cnt_q != 32'hFFFFFFFF)) begin
                load_cnt_q <= load_cnt_q + 32'd1;
            end
            if (stall[0] && (total_cnt_q != 32'hFFFFFFFF)) begin
                total_cnt_q <= total_cnt_q + 32'd1;
            end
        end
    end

    assign bus.load_stall_cnt  = load_cnt_q;
    assign bus.total_stall_cnt = total_cnt_q;
`else
    assign bus.load_stall_cnt  = 32'h0;
    assign bus.total_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl: stall priority, redirects, fetch wait, timeout.
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    pipeline_ctrl_if bus ();

    pipeline_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs;
        bus.request_from_if  = 1'b0;
        bus.load_related_1   = 1'b0;
        bus.load_related_2   = 1'b0;
        bus.request_from_ex  = 1'b0;
        bus.request_from_mem = 1'b0;
        bus.exception_flag   = 1'b0;
        bus.eret_flag        = 1'b0;
        bus.epc              = 32'h0;
    endtask

    // Inputs change just after the rising edge; outputs are checked on the falling edge.
    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        next_cycle();
        rst = 1'b1;
        bus.exception_flag   = 1'b1;
        bus.request_from_mem = 1'b1;
        bus.load_related_1   = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.stall !== 6'b000000) begin
            n_fail++; $display("FAIL reset_stall actual=%b required=000000", bus.stall);
        end
        n_checks++;
        if (bus.flush !== 1'b0 || bus.redirect_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flush_rv actual=%b%b required=00", bus.flush, bus.redirect_valid);
        end
        n_checks++;
        if (bus.redirect_pc !== 32'h0) begin
            n_fail++; $display("FAIL reset_pc actual=%h required=0", bus.redirect_pc);
        end
        next_cycle();
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (bus.fetch_timeout !== 1'b0 || bus.stall !== 6'b0) begin
            n_fail++;
            $display("FAIL post_reset actual=timeout %b stall %b required=0 000000",
                     bus.fetch_timeout, bus.stall);
        end
        n_checks++;
        if (bus.load_stall_cnt !== 32'h0 || bus.total_stall_cnt !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_counters actual=%0d/%0d required=0/0",
                     bus.load_stall_cnt, bus.total_stall_cnt);
        end
    endtask

    task automatic test_load_stall;
        next_cycle();
        bus.load_related_1 = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.stall !== 6'b000111) begin
            n_fail++; $display("FAIL load_stall actual=%b required=000111", bus.stall);
        end
        next_cycle();
        bus.load_related_1 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.stall !== 6'b000000) begin
            n_fail++; $display("FAIL load_release actual=%b required=000000", bus.stall);
        end
`ifdef PIPELINE_PERF_CNT_EN
        n_checks++;
        if (bus.load_stall_cnt !== 32'd1 || bus.total_stall_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL perf_counters actual=%0d/%0d required=1/1",
                     bus.load_stall_cnt, bus.total_stall_cnt);
        end
`else
        n_checks++;
        if (bus.load_stall_cnt !== 32'd0 || bus.total_stall_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_tied_off actual=%0d/%0d required=0/0",
                     bus.load_stall_cnt, bus.total_stall_cnt);
        end
`endif
    endtask

    task automatic test_priority;
        // {mem, ex, lr1, lr2, if} -> expected stall vector
        logic [4:0] req [5] = '{5'b11010, 5'b01101, 5'b00011, 5'b00001, 5'b10001};
        logic [5:0] exp [5] = '{6'b011111, 6'b001111, 6'b000111, 6'b000011, 6'b011111};
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            {bus.request_from_mem, bus.request_from_ex, bus.load_related_1,
             bus.load_related_2, bus.request_from_if} = req[i];
            @(negedge clk);
            n_checks++;
            if (bus.stall !== exp[i] || bus.flush !== 1'b0) begin
                n_fail++;
                $display("FAIL priority_%0d actual=%b flush %b required=%b flush 0",
                         i, bus.stall, bus.flush, exp[i]);
            end
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_exception_idle;
        bus.exception_flag = 1'b1;
        bus.eret_flag      = 1'b1;
        bus.epc            = 32'h12345678;
        bus.load_related_2 = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.flush !== 1'b1 || bus.redirect_valid !== 1'b1 || bus.stall !== 6'b0) begin
            n_fail++;
            $display("FAIL exc_idle_ctrl actual=flush %b rv %b stall %b required=1 1 000000",
                     bus.flush, bus.redirect_valid, bus.stall);
        end
        n_checks++;
        if (bus.redirect_pc !== 32'hBFC00380) begin
            n_fail++; $display("FAIL exc_idle_pc actual=%h required=bfc00380", bus.redirect_pc);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (bus.flush !== 1'b0 || bus.redirect_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL exc_idle_after actual=%b%b required=00", bus.flush, bus.redirect_valid);
        end
    endtask

    task automatic test_eret_wait;
        next_cycle();
        bus.eret_flag       = 1'b1;
        bus.epc             = 32'h80001000;
        bus.request_from_if = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.flush !== 1'b1 || bus.redirect_valid !== 1'b0 || bus.stall !== 6'b000011) begin
            n_fail++;
            $display("FAIL eret_c0 actual=flush %b rv %b stall %b required=1 0 000011",
                     bus.flush, bus.redirect_valid, bus.stall);
        end
        for (int c = 1; c <= 2; c++) begin
            next_cycle();
            bus.eret_flag = 1'b0;
            bus.epc       = 32'h0;
            bus.load_related_1 = 1'b1;
            @(negedge clk);
            n_checks++;
            if (bus.stall !== 6'b000011 || bus.flush !== 1'b0 || bus.redirect_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL eret_c%0d actual=stall %b flush %b rv %b required=000011 0 0",
                         c, bus.stall, bus.flush, bus.redirect_valid);
            end
        end
        next_cycle();
        bus.request_from_if = 1'b0;
        bus.load_related_1  = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h80001000) begin
            n_fail++;
            $display("FAIL eret_c3 actual=rv %b pc %h required=1 80001000",
                     bus.redirect_valid, bus.redirect_pc);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (bus.redirect_valid !== 1'b0 || bus.stall !== 6'b0) begin
            n_fail++;
            $display("FAIL eret_idle actual=rv %b stall %b required=0 000000",
                     bus.redirect_valid, bus.stall);
        end
    endtask

    task automatic test_deferred_exception;
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            bus.exception_flag   = 1'b1;
            bus.request_from_mem = 1'b1;
            @(negedge clk);
            n_checks++;
            if (bus.flush !== 1'b0 || bus.redirect_valid !== 1'b0 || bus.stall !== 6'b011111) begin
                n_fail++;
                $display("FAIL defer_c%0d actual=flush %b rv %b stall %b required=0 0 011111",
                         c, bus.flush, bus.redirect_valid, bus.stall);
            end
        end
        next_cycle();
        bus.request_from_mem = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.flush !== 1'b1 || bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'hBFC00380) begin
            n_fail++;
            $display("FAIL defer_c2 actual=flush %b rv %b pc %h required=1 1 bfc00380",
                     bus.flush, bus.redirect_valid, bus.redirect_pc);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_wait_overwrite;
        // Later redirect replaces the pending one while the fetch is still outstanding.
        bus.eret_flag       = 1'b1;
        bus.epc             = 32'h80002000;
        bus.request_from_if = 1'b1;
        next_cycle();
        bus.eret_flag      = 1'b0;
        bus.exception_flag = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.flush !== 1'b1 || bus.redirect_valid !== 1'b0 || bus.stall !== 6'b000011) begin
            n_fail++;
            $display("FAIL ovr_flush actual=flush %b rv %b stall %b required=1 0 000011",
                     bus.flush, bus.redirect_valid, bus.stall);
        end
        next_cycle();
        bus.exception_flag  = 1'b0;
        bus.request_from_if = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'hBFC00380) begin
            n_fail++;
            $display("FAIL ovr_pc actual=rv %b pc %h required=1 bfc00380",
                     bus.redirect_valid, bus.redirect_pc);
        end
        // New redirect in the same cycle the fetch completes goes out directly.
        next_cycle();
        bus.eret_flag       = 1'b1;
        bus.epc             = 32'h80003000;
        bus.request_from_if = 1'b1;
        next_cycle();
        bus.epc             = 32'h80004000;
        bus.request_from_if = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.flush !== 1'b1 || bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h80004000) begin
            n_fail++;
            $display("FAIL ovr_same actual=flush %b rv %b pc %h required=1 1 80004000",
                     bus.flush, bus.redirect_valid, bus.redirect_pc);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_timeout;
        bus.exception_flag  = 1'b1;
        bus.request_from_if = 1'b1;
        next_cycle();
        bus.exception_flag = 1'b0;
        repeat (59) next_cycle();
        @(negedge clk);
        n_checks++;
        if (bus.fetch_timeout !== 1'b0 || bus.stall !== 6'b000011) begin
            n_fail++;
            $display("FAIL timeout_early actual=%b stall %b required=0 000011",
                     bus.fetch_timeout, bus.stall);
        end
        repeat (10) next_cycle();
        @(negedge clk);
        n_checks++;
        if (bus.fetch_timeout !== 1'b1 || bus.redirect_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_set actual=%b rv %b required=1 0",
                     bus.fetch_timeout, bus.redirect_valid);
        end
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.stall !== 6'b0 || bus.redirect_valid !== 1'b0 || bus.flush !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_rst_out actual=stall %b rv %b flush %b required=000000 0 0",
                     bus.stall, bus.redirect_valid, bus.flush);
        end
        next_cycle();
        rst = 1'b0;
        bus.load_related_1 = 1'b1;
        @(negedge clk);
        // IDLE gives the load-stall vector here; a leftover WAIT_FETCH would show 000011.
        n_checks++;
        if (bus.fetch_timeout !== 1'b0 || bus.stall !== 6'b000111 || bus.redirect_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_cleared actual=to %b stall %b rv %b required=0 000111 0",
                     bus.fetch_timeout, bus.stall, bus.redirect_valid);
        end
        bus.request_from_if = 1'b0;
        bus.load_related_1  = 1'b0;
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (bus.redirect_valid !== 1'b0 || bus.stall !== 6'b0) begin
            n_fail++;
            $display("FAIL timeout_idle actual=rv %b stall %b required=0 000000",
                     bus.redirect_valid, bus.stall);
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_load_stall();
        test_priority();
        test_exception_idle();
        test_eret_wait();
        test_deferred_exception();
        test_wait_overwrite();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
